// File: rtl/and3_gate.sv
// Three-input AND cell with a registered copy and optional rising-edge statistics.
// Define AND3_GATE_STATS_EN to build the y_rise pulse and saturating rise_cnt counter.
module and3_gate #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             clr,
    output logic             y,
    output logic             y_q,
    output logic             y_rise,
    output logic [CNT_W-1:0] rise_cnt
);

    // A 0 on any operand forces 0 even when another operand is X/Z.
    assign y = a & b & c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= 1'b0;
        end else begin
            y_q <= y;
        end
    end

`ifdef AND3_GATE_STATS_EN
    logic             rise_d;
    logic             rise_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // clr beats a same-cycle rising event; the counter holds at all-ones.
    always_comb begin
        rise_d = y & ~y_q;
        cnt_d  = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (rise_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            rise_q <= rise_d;
            cnt_q  <= cnt_d;
        end
    end

    assign y_rise   = rise_q;
    assign rise_cnt = cnt_q;
`else
    logic unused_clr;
    assign unused_clr = clr;

    assign y_rise   = 1'b0;
    assign rise_cnt = '0;
`endif

endmodule

// File: tb/tb_and3_gate.sv
// Self-checking bench for and3_gate: a CNT_W=16 instance and a CNT_W=2 instance share stimulus.
// Expected statistics follow AND3_GATE_STATS_EN, so the bench works with either build.
module tb_and3_gate;

`ifdef AND3_GATE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        a;
    logic        b;
    logic        c;
    logic        clr;
    logic        y;
    logic        y_q;
    logic        y_rise;
    logic [15:0] rise_cnt;
    logic        y2;
    logic        y_q2;
    logic        y_rise2;
    logic [1:0]  rise_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: previous sampled y, last pulse, and integer counts clipped at their maxima.
    bit m_yq;
    bit m_rise;
    int m_cnt;
    int m_cnt2;

    and3_gate #(.CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .c        (c),
        .clr      (clr),
        .y        (y),
        .y_q      (y_q),
        .y_rise   (y_rise),
        .rise_cnt (rise_cnt)
    );

    and3_gate #(.CNT_W(2)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .c        (c),
        .clr      (clr),
        .y        (y2),
        .y_q      (y_q2),
        .y_rise   (y_rise2),
        .rise_cnt (rise_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit exp_rise();
        return STATS ? m_rise : 1'b0;
    endfunction

    function automatic logic [15:0] exp_cnt();
        return STATS ? 16'(m_cnt) : 16'd0;
    endfunction

    function automatic logic [1:0] exp_cnt2();
        return STATS ? 2'(m_cnt2) : 2'd0;
    endfunction

    task automatic model_reset();
        m_yq   = 1'b0;
        m_rise = 1'b0;
        m_cnt  = 0;
        m_cnt2 = 0;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, return 1 ns after it.
    task automatic step(input bit ia, input bit ib, input bit ic, input bit iclr);
        bit yv;
        a   = ia;
        b   = ib;
        c   = ic;
        clr = iclr;
        @(posedge clk);
        yv     = ia && ib && ic;
        m_rise = yv && !m_yq;
        if (iclr) begin
            m_cnt  = 0;
            m_cnt2 = 0;
        end else if (m_rise) begin
            m_cnt  = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
            m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : m_cnt2;
        end
        m_yq = yv;
        #1;
    endtask

    task automatic test_reset();
        logic [2:0] v;
        rst = 1'b1;
        {a, b, c, clr} = 4'b0;
        model_reset();
        #1;
        n_checks++;
        if ({y_q, y_rise, rise_cnt} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_state: got y_q=%b y_rise=%b cnt=%0d, want 0 0 0", y_q, y_rise, rise_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            a = v[0];
            b = v[1];
            c = v[2];
            #10;
            n_checks++;
            if (y !== (i == 7)) begin
                n_fail++;
                $display("FAIL sweep abc=%b%b%b: got y=%b, want %b", a, b, c, y, i == 7);
            end
        end
        n_checks++;
        if ({y_q, y_rise, rise_cnt, y_q2, y_rise2, rise_cnt2} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got y_q=%b y_rise=%b cnt=%0d, want 0 0 0", y_q, y_rise, rise_cnt);
        end
        a = 1'bx;
        b = 1'b0;
        c = 1'b1;
        #1;
        n_checks++;
        if (y !== 1'b0) begin
            n_fail++;
            $display("FAIL x_masked: got y=%b, want 0", y);
        end
        {a, b, c} = 3'b000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_register_path();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (y_q !== 1'b1 || y_rise !== STATS || rise_cnt !== 16'(STATS)) begin
            n_fail++;
            $display("FAIL reg_first_edge: got y_q=%b y_rise=%b cnt=%0d, want 1 %b %0d",
                     y_q, y_rise, rise_cnt, STATS, STATS);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0);
            n_checks++;
            if (y_q !== 1'b1 || y_rise !== 1'b0 || rise_cnt !== 16'(STATS)) begin
                n_fail++;
                $display("FAIL reg_hold%0d: got y_q=%b y_rise=%b cnt=%0d, want 1 0 %0d",
                         i, y_q, y_rise, rise_cnt, STATS);
            end
        end
    endtask

    task automatic test_saturation();
        int want [5] = '{1, 2, 3, 3, 3};
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0);
            n_checks++;
            if (rise_cnt2 !== (STATS ? 2'(want[i]) : 2'd0) || rise_cnt2 !== exp_cnt2()) begin
                n_fail++;
                $display("FAIL saturate%0d: got cnt=%0d, want %0d", i, rise_cnt2,
                         STATS ? want[i] : 0);
            end
            step(1'b0, 1'b1, 1'b1, 1'b0);
        end
    endtask

    task automatic test_clear_priority();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (rise_cnt !== 16'(STATS ? 2 : 0)) begin
            n_fail++;
            $display("FAIL clr_setup: got cnt=%0d, want %0d", rise_cnt, STATS ? 2 : 0);
        end
        step(1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (rise_cnt !== 16'd0 || y_rise !== STATS || rise_cnt2 !== 2'd0) begin
            n_fail++;
            $display("FAIL clr_priority: got cnt=%0d y_rise=%b, want 0 %b", rise_cnt, y_rise, STATS);
        end
    endtask

    task automatic test_async_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b1, 1'b0);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (y_q !== 1'b1 || rise_cnt !== 16'(STATS ? 6 : 0)) begin
            n_fail++;
            $display("FAIL arst_setup: got y_q=%b cnt=%0d, want 1 %0d", y_q, rise_cnt, STATS ? 6 : 0);
        end
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({y_q, y_rise, rise_cnt, y_q2, y_rise2, rise_cnt2} !== 22'd0) begin
            n_fail++;
            $display("FAIL arst_clear: got y_q=%b y_rise=%b cnt=%0d, want 0 0 0", y_q, y_rise, rise_cnt);
        end
        n_checks++;
        if (y !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_y_high: got y=%b, want 1", y);
        end
        c = 1'b0;
        #1;
        n_checks++;
        if (y !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_y_low: got y=%b, want 0", y);
        end
        c = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
        step(1'b1, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (y_q !== 1'b1 || rise_cnt !== 16'(STATS) || y_rise !== STATS) begin
            n_fail++;
            $display("FAIL arst_release: got y_q=%b y_rise=%b cnt=%0d, want 1 %b %0d",
                     y_q, y_rise, rise_cnt, STATS, STATS);
        end
    endtask

    task automatic test_random();
        bit ia, ib, ic, iclr;
        for (int i = 0; i < 300; i++) begin
            ia   = $urandom_range(0, 3) != 0;
            ib   = $urandom_range(0, 3) != 0;
            ic   = $urandom_range(0, 3) != 0;
            iclr = $urandom_range(0, 15) == 0;
            step(ia, ib, ic, iclr);
            n_checks++;
            if (y !== (ia && ib && ic) || y_q !== m_yq || y_rise !== exp_rise() ||
                rise_cnt !== exp_cnt() || y_rise2 !== exp_rise() || rise_cnt2 !== exp_cnt2()) begin
                n_fail++;
                $display("FAIL random%0d: got y=%b y_q=%b rise=%b cnt=%0d cnt2=%0d, want %b %b %b %0d %0d",
                         i, y, y_q, y_rise, rise_cnt, rise_cnt2, ia && ib && ic, m_yq,
                         exp_rise(), exp_cnt(), exp_cnt2());
            end
        end
    endtask

    initial begin
        test_reset();
        test_register_path();
        test_saturation();
        test_clear_priority();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
